// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Optional signed-overflow output is enabled with SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int DEF_WIDTH = 8;

  // Counter must hold 0..WIDTH
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder used for the per-cycle sum/carry step.
// Purely combinational.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one bit per cycle, WIDTH cycles per add.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             s_bit, c_bit;
  logic             accept, last;

  fa_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (s_bit),
    .co (c_bit)
  );

  assign accept = start & (state_q != RUN);
  assign last   = (state_q == RUN) & (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          sum_d   = '0;
          cnt_d   = '0;
          carry_d = cin;
          cout_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {s_bit, sum_q[WIDTH-1:1]};
        carry_d = c_bit;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cout_d  = c_bit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // carry_q is the carry into the MSB on the last bit
  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if (last) begin
      ovf_d = carry_q ^ c_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed adds, mid-run start,
// mid-run reset. Honors SERIAL_ADDER_OVF_EN when defined.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    string        name;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks;
  int failures;
  exp_t sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_sum"}, 32'(sum), 32'(e.sum));
        chk({e.name, "_cout"}, 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        chk({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Issue one add; optionally poke start with new operands mid-run
  task automatic op(input string nm, input logic [W-1:0] va,
                    input logic [W-1:0] vb, input logic vc,
                    input logic [W-1:0] es, input logic ec,
                    input logic eo, input bit inj);
    exp_t e;
    int k;
    int nbusy;
    @(negedge clk);
    start = 1'b1;
    a = va;
    b = vb;
    cin = vc;
    e.sum = es;
    e.cout = ec;
    e.ovf = eo;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    nbusy = 0;
    k = 0;
    while (!done && k < 40) begin
      if (busy) nbusy++;
      if (inj && k == 3) begin
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, 32'(k), 32'(W));
    chk({nm, "_busy_cycles"}, 32'(nbusy), 32'(W));
    chk({nm, "_busy_in_done"}, 32'(busy), 32'(0));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    op("0F_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    op("FF_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    op("7F_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    op("FF_00_c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    op("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    op("A5_5A_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    op("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

    // Result must hold after done while idle
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sum", 32'(sum), 32'h46);
    chk("hold_busy", 32'(busy), 32'(0));

    op("inj", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("inj_no_second_op", 32'(busy), 32'(0));

    // Reset in the middle of a run
    @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(busy), 32'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_idle", 32'(busy), 32'(0));

    op("01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to add the presented operands; sampled only when busy=0.
REQ-005 Port: a  input  WIDTH  operand A, captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  operand B, captured on the accepting edge.
REQ-007 Port: cin  input  1  carry-in, captured on the accepting edge.
REQ-008 Port: busy  output  1  high while bits are being processed.
REQ-009 Port: done  output  1  single-cycle pulse marking valid sum/cout.
REQ-010 Port: sum  output  WIDTH  result register.
REQ-011 Port: cout  output  1  final carry-out.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-013 IDLE or DONE with start=1 SHALL go to RUN, load the A/B shift registers, load the carry flop with cin, and clear the bit counter.
REQ-014 DONE with start=0 SHALL go to IDLE.
REQ-015 IDLE with start=0 SHALL hold.
REQ-016 RUN SHALL process one bit per cycle, LSB first: sum_bit = a0^b0^carry; carry <= majority(a0,b0,carry).
REQ-017 In RUN, the operand registers SHALL shift right and sum_bit SHALL shift into the result MSB.
REQ-018 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE; done SHALL be high in the cycle beginning WIDTH edges after the accepting edge.
REQ-019 busy SHALL equal 1 only in RUN; start during RUN SHALL be ignored and the captured operands SHALL be unaffected.
REQ-020 In DONE, sum and cout SHALL equal (a+b+cin) mod 2^WIDTH and its carry.
REQ-021 sum and cout SHALL hold their values until the next accepted start; intermediate shifting SHALL be visible on sum during RUN.
REQ-022 Changes on a, b and cin outside the accepting edge SHALL have no effect.

Reset
REQ-023 rst_n low SHALL immediately force the state to IDLE, busy=0, done=0, sum=0, cout=0, the counter to 0 and the carry flop to 0, regardless of clock.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow release.
REQ-025 The first start after reset release SHALL be accepted normally.

Configuration
REQ-026 With SERIAL_ADDER_OVF_EN defined, the block SHALL add the output port ovf (output, 1 bit): signed overflow = carry into MSB XOR cout, latched with the MSB bit, reset to 0 and held like cout.
REQ-027 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-028 The package serial_adder_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the counter-width helper constant, computed as clog2 of WIDTH+1.
REQ-029 The per-bit sum/carry logic SHALL be a combinational sub-module fa_cell (inputs x, y, ci; outputs s, co), instantiated once.

Verification
REQ-030 WIDTH=8, a=0x0F, b=0x01, cin=0, start pulse -> busy for 8 cycles, then done=1 for one cycle, sum=0x10, cout=0.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with SERIAL_ADDER_OVF_EN, ovf=0.
REQ-032 a=0x7F, b=0x01, cin=0, with SERIAL_ADDER_OVF_EN -> sum=0x80, cout=0, ovf=1.
REQ-033 a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-034 Start a=0x0F, b=0x01, then at RUN cycle 3 drive start=1 with a=0xAA, b=0x55 -> result 0x10, with no second operation.
REQ-035 Start a=0xFF, b=0xFF, then assert rst_n=0 at RUN cycle 4 -> outputs go to 0 at once; after release, no done appears, and a new start a=0x01, b=0x02 gives sum=0x03.
